// File: rtl/stream_demux_if.sv
// Handshake/bus bundle for stream_demux.
//   in_valid/in_ready/in_data/in_sel : single producer side
//   out_valid/out_ready/out_data     : N_OUT consumers, shared data bus
//   drop/drop_cnt                    : out-of-range destination reporting
// Modports: master = producer/consumer environment, slave = the demux.
interface stream_demux_if #(
    parameter int N_OUT = 4,
    parameter int W     = 8,
    parameter int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [SEL_W-1:0] in_sel;
    logic [N_OUT-1:0] out_valid;
    logic [N_OUT-1:0] out_ready;
    logic [W-1:0]     out_data;
    logic             drop;
    logic [7:0]       drop_cnt;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, drop, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, drop, drop_cnt
    );
endinterface

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N stream demultiplexer, valid/ready handshake.
// One holding register {full, dest, data}; each accepted beat is steered to
// the channel chosen by in_sel and appears one cycle later. Full throughput
// when the target consumer is ready.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    stream_demux_if.slave (in_* producer side, out_* consumers,
//          drop pulse and saturating drop_cnt for out-of-range in_sel)
// Optional feature: define STREAM_DEMUX_RR_EN to ignore in_sel and route
// beats round-robin over the channels (no drops in that mode).
module stream_demux #(
    parameter int N_OUT = 4,
    parameter int W     = 8,
    parameter int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_demux_if.slave  bus
);
    typedef enum logic {EMPTY, FULL} state_e;

    localparam logic [SEL_W:0]   N_OUT_W = (SEL_W+1)'(N_OUT);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_OUT - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] dest_q, dest_d;
    logic [W-1:0]     data_q, data_d;
    logic             drop_q, drop_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic [SEL_W-1:0] tgt_sel;
    logic             in_range;
    logic             drain;
    logic             accept;
    logic [N_OUT-1:0] out_valid_c;

`ifdef STREAM_DEMUX_RR_EN
    logic [SEL_W-1:0] rr_q, rr_d;

    // Destination comes from the pointer, so every beat is in range.
    assign tgt_sel  = rr_q;
    assign in_range = 1'b1;

    always_comb begin
        rr_d = rr_q;
        if (accept)
            rr_d = (rr_q == LAST_CH) ? '0 : rr_q + SEL_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= '0;
        else        rr_q <= rr_d;
    end
`else
    assign tgt_sel  = bus.in_sel;
    assign in_range = {1'b0, bus.in_sel} < N_OUT_W;
`endif

    // Only the addressed consumer's ready matters; the others are ignored.
    assign drain  = (state_q == FULL) && bus.out_ready[dest_q];
    assign accept = bus.in_valid && bus.in_ready;

    assign bus.in_ready = (state_q == EMPTY) || drain;

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        data_d     = data_q;
        drop_d     = 1'b0;
        drop_cnt_d = drop_cnt_q;
        // A drain frees the slot; a same-cycle in-range accept refills it.
        if (drain)
            state_d = EMPTY;
        if (accept) begin
            if (in_range) begin
                state_d = FULL;
                dest_d  = tgt_sel;
                data_d  = bus.in_data;
            end else begin
                // Handshake completes but the beat is discarded.
                drop_d = 1'b1;
                if (drop_cnt_q != 8'hFF)
                    drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            dest_q     <= '0;
            data_q     <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            data_q     <= data_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        out_valid_c = '0;
        for (int k = 0; k < N_OUT; k++)
            if ((state_q == FULL) && (dest_q == SEL_W'(k)))
                out_valid_c[k] = 1'b1;
    end

    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = data_q;   // holds last value when empty
    assign bus.drop      = drop_q;
    assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_stream_demux.sv
// Testbench for stream_demux: directed table, hand-written corner sequences
// and a randomized run against a slot-occupancy reference model. Two
// instances: N_OUT=4 (full select range) and N_OUT=3 (sel=3 out of range).
module tb_stream_demux;
`ifdef STREAM_DEMUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_demux_if #(.N_OUT(4), .W(8)) b4();
    stream_demux_if #(.N_OUT(3), .W(8)) b3();

    stream_demux #(.N_OUT(4), .W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    stream_demux #(.N_OUT(3), .W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed vector: inputs applied before an edge; in_ready checked
    // before the edge, out_valid/out_data after it.
    typedef struct {
        bit       iv;
        int       sel;
        int       dat;
        int       ordy;
        int       exp_ir;
        int       exp_ov;
        int       exp_od;
    } vec_t;

    vec_t vecs[12];
    int   nvec;

    // Reference model: one-slot buffer described by occupancy.
    typedef struct {
        bit has;
        int ch;
        int dat;
        bit drop;
        int cnt;
        int rr;
    } m_t;

    function automatic m_t mreset();
        m_t m;
        m.has = 0; m.ch = 0; m.dat = 0; m.drop = 0; m.cnt = 0; m.rr = 0;
        return m;
    endfunction

    function automatic bit mroom(input m_t m, input logic [3:0] ordy);
        return !m.has || (ordy[m.ch] == 1'b1);
    endfunction

    function automatic int mov(input m_t m);
        return m.has ? (1 << m.ch) : 0;
    endfunction

    task automatic mstep(inout m_t m, input int n, input bit iv, input int sel,
                         input int din, input logic [3:0] ordy);
        bit room;
        int tgt;
        room   = mroom(m, ordy);
        tgt    = RR ? m.rr : sel;
        m.drop = 0;
        if (m.has && ordy[m.ch] == 1'b1) m.has = 0;
        if (iv && room) begin
            if (tgt < n) begin
                m.has = 1; m.ch = tgt; m.dat = din;
            end else begin
                m.drop = 1;
                if (m.cnt < 255) m.cnt++;
            end
            m.rr = (m.rr + 1) % n;
        end
    endtask

    task automatic idle();
        b4.in_valid = 0; b4.in_sel = '0; b4.in_data = '0; b4.out_ready = '0;
        b3.in_valid = 0; b3.in_sel = '0; b3.in_data = '0; b3.out_ready = '0;
    endtask

    m_t m4, m3;

    initial begin
        idle();
        // ---------------- reset state ----------------
        #12;
        chk("rst_ov", b4.out_valid, 0);
        chk("rst_od", b4.out_data, 0);
        chk("rst_drop", b3.drop, 0);
        chk("rst_cnt", b3.drop_cnt, 0);
        chk("rst_ir", b4.in_ready, 1);
        @(negedge clk) rst_n = 1;
        tick();

        // ---------------- single beat, latency 1 ----------------
        b4.in_valid = 1; b4.in_sel = 2; b4.in_data = 8'hA5; b4.out_ready = 4'hF;
        #1 chk("t1_ir", b4.in_ready, 1);
        tick();
        b4.in_valid = 0;
        chk("t1_ov", b4.out_valid, RR ? 4'b0001 : 4'b0100);
        chk("t1_od", b4.out_data, 8'hA5);
        tick();
        chk("t1_ov_empty", b4.out_valid, 0);
        chk("t1_od_hold", b4.out_data, 8'hA5);

        // ---------------- table (fresh reset) ----------------
        rst_n = 0; #2; rst_n = 1; #1;
`ifdef STREAM_DEMUX_RR_EN
        nvec = 5;
        vecs[0] = '{1, 0, 8'h10, 4'hF, 1, 4'b0001, 8'h10};
        vecs[1] = '{1, 0, 8'h11, 4'hF, 1, 4'b0010, 8'h11};
        vecs[2] = '{1, 0, 8'h12, 4'hF, 1, 4'b0100, 8'h12};
        vecs[3] = '{1, 0, 8'h13, 4'hF, 1, 4'b1000, 8'h13};
        vecs[4] = '{1, 0, 8'h14, 4'hF, 1, 4'b0001, 8'h14};
`else
        nvec = 12;
        vecs[0]  = '{1, 0, 8'h10, 4'hF, 1, 4'b0001, 8'h10};
        vecs[1]  = '{1, 1, 8'h11, 4'hF, 1, 4'b0010, 8'h11};
        vecs[2]  = '{1, 2, 8'h12, 4'hF, 1, 4'b0100, 8'h12};
        vecs[3]  = '{1, 3, 8'h13, 4'hF, 1, 4'b1000, 8'h13};
        vecs[4]  = '{1, 1, 8'h20, 4'hF, 1, 4'b0010, 8'h20};
        vecs[5]  = '{1, 0, 8'h21, 4'hD, 0, 4'b0010, 8'h20};
        vecs[6]  = '{1, 0, 8'h22, 4'hD, 0, 4'b0010, 8'h20};
        vecs[7]  = '{1, 0, 8'h23, 4'hD, 0, 4'b0010, 8'h20};
        vecs[8]  = '{0, 0, 8'h24, 4'hF, 1, 4'b0000, 8'h20};
        vecs[9]  = '{1, 3, 8'h30, 4'h0, 1, 4'b1000, 8'h30};
        vecs[10] = '{1, 0, 8'h31, 4'h7, 0, 4'b1000, 8'h30};
        vecs[11] = '{0, 0, 8'h32, 4'h8, 1, 4'b0000, 8'h30};
`endif
        for (int i = 0; i < nvec; i++) begin
            b4.in_valid  = vecs[i].iv;
            b4.in_sel    = 2'(vecs[i].sel);
            b4.in_data   = 8'(vecs[i].dat);
            b4.out_ready = 4'(vecs[i].ordy);
            #1 chk($sformatf("vec%0d_ir", i), b4.in_ready, vecs[i].exp_ir);
            tick();
            chk($sformatf("vec%0d_ov", i), b4.out_valid, vecs[i].exp_ov);
            chk($sformatf("vec%0d_od", i), b4.out_data, vecs[i].exp_od);
        end
        idle();
        tick();

`ifndef STREAM_DEMUX_RR_EN
        // ---------------- out-of-range drop (N_OUT=3) ----------------
        b3.in_valid = 1; b3.in_sel = 3; b3.in_data = 8'h55; b3.out_ready = 3'h7;
        #1 chk("t4_ir", b3.in_ready, 1);
        tick();
        b3.in_valid = 0;
        chk("t4_drop", b3.drop, 1);
        chk("t4_ov", b3.out_valid, 0);
        chk("t4_cnt", b3.drop_cnt, 1);
        tick();
        chk("t4_drop_pulse", b3.drop, 0);
        // drop coinciding with a drain: slot must empty
        b3.in_valid = 1; b3.in_sel = 0; b3.in_data = 8'h66; b3.out_ready = 3'h0;
        tick();
        chk("t4_load_ov", b3.out_valid, 3'b001);
        b3.in_sel = 3; b3.in_data = 8'h67; b3.out_ready = 3'b001;
        #1 chk("t4_dd_ir", b3.in_ready, 1);
        tick();
        b3.in_valid = 0;
        chk("t4_dd_ov", b3.out_valid, 0);
        chk("t4_dd_drop", b3.drop, 1);
        chk("t4_dd_cnt", b3.drop_cnt, 2);
        chk("t4_dd_od", b3.out_data, 8'h66);
        // saturation
        b3.in_valid = 1; b3.in_sel = 3;
        repeat (300) @(posedge clk);
        #1;
        chk("t4_sat", b3.drop_cnt, 255);
        b3.in_valid = 0;
        tick();
`endif

        // ---------------- async reset while full ----------------
        b4.in_valid = 1; b4.in_sel = 1; b4.in_data = 8'h77; b4.out_ready = 4'h0;
        tick();
        b4.in_valid = 0;
        chk("t5_full", (b4.out_valid != 0), 1);
        rst_n = 0;
        #1;
        chk("t5_ov", b4.out_valid, 0);
        chk("t5_od", b4.out_data, 0);
        chk("t5_cnt", b3.drop_cnt, 0);
        chk("t5_drop", b3.drop, 0);
        idle();
        @(negedge clk) rst_n = 1;
        tick();

        // ---------------- randomized vs model ----------------
        m4 = mreset();
        m3 = mreset();
        for (int c = 0; c < 600; c++) begin
            b4.in_valid  = ($urandom_range(0, 3) != 0);
            b4.in_sel    = 2'($urandom_range(0, 3));
            b4.in_data   = 8'($urandom);
            b4.out_ready = 4'($urandom);
            b3.in_valid  = ($urandom_range(0, 3) != 0);
            b3.in_sel    = 2'($urandom_range(0, 3));
            b3.in_data   = 8'($urandom);
            b3.out_ready = 3'($urandom);
            #1;
            chk("r4_ir", b4.in_ready, mroom(m4, b4.out_ready));
            chk("r3_ir", b3.in_ready, mroom(m3, {1'b0, b3.out_ready}));
            mstep(m4, 4, b4.in_valid, int'(b4.in_sel), int'(b4.in_data), b4.out_ready);
            mstep(m3, 3, b3.in_valid, int'(b3.in_sel), int'(b3.in_data), {1'b0, b3.out_ready});
            tick();
            chk("r4_ov", b4.out_valid, mov(m4));
            chk("r4_od", b4.out_data, m4.dat);
            chk("r4_drop", b4.drop, 0);
            chk("r3_ov", b3.out_valid, mov(m3));
            chk("r3_od", b3.out_data, m3.dat);
            chk("r3_drop", b3.drop, m3.drop);
            chk("r3_cnt", b3.drop_cnt, m3.cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
